// File: rtl/mem_pkg.sv
// mem_pkg: shared size/state encodings and byte-lane helpers for the MEM-stage access unit.
package mem_pkg;
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam int TIMEOUT_DEFAULT = 255;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_BUSY = 2'b01, S_DONE = 2'b10} state_t;
  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lo);
    return size == SIZE_BYTE ? 4'b0001 << lo :
           size == SIZE_HALF ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] d);
    return size == SIZE_BYTE ? {4{d[7:0]}} : size == SIZE_HALF ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed lane of a read word and zero/sign-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_signed,
  output logic [31:0] o_data
);
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_shift = i_rdata >> {i_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign o_data  = i_size == SIZE_BYTE ? {{24{i_signed & w_byte[7]}}, w_byte} :
                   i_size == SIZE_HALF ? {{16{i_signed & w_half[15]}}, w_half} : i_rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a req/ack bus, stalling the
// pipeline until completion and flagging misaligned accesses and bus timeouts.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd_in,
  input  logic        MemWr_in,
  input  logic [31:0] ALUOut_in,
  input  logic [31:0] DatabusB_in,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ReadData_out,
  output logic        stall_out,
  output logic        misalign_out,
  output logic        bus_err_out
);
  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [1:0]  r_size, r_lane;
  logic        r_signed;
  logic        w_access, w_word, w_mis, w_start, w_timeout;
  logic [31:0] w_load;
  assign w_access  = MemRd_in | MemWr_in;
  assign w_word    = mem_size == SIZE_WORD || mem_size == 2'b11;
  assign w_mis     = (w_word && ALUOut_in[1:0] != 2'b00) || (mem_size == SIZE_HALF && ALUOut_in[0]);
  assign w_start   = r_state == S_IDLE && w_access && !w_mis;
  assign w_timeout = r_state == S_BUSY && !bus_ack && r_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign stall_out = w_start || r_state == S_BUSY;
  load_align u_align (
    .i_rdata (bus_rdata),
    .i_size  (r_size),
    .i_lane  (r_lane),
    .i_signed(r_signed),
    .o_data  (w_load)
  );
  // DONE and the unused encoding both fall back to IDLE
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_start ? S_BUSY : S_IDLE;
      S_BUSY:  w_next = (bus_ack || w_timeout) ? S_DONE : S_BUSY;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_size       <= SIZE_WORD;
      r_lane       <= '0;
      r_signed     <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_be       <= '0;
      ReadData_out <= '0;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
    end else begin
      r_state      <= w_next;
      misalign_out <= r_state == S_IDLE && w_access && w_mis;
      bus_err_out  <= w_timeout;
      if (w_start) begin
        bus_req   <= 1'b1;
        bus_we    <= MemWr_in;
        bus_addr  <= {ALUOut_in[31:2], 2'b00};
        bus_be    <= calc_be(mem_size, ALUOut_in[1:0]);
        bus_wdata <= calc_wdata(mem_size, DatabusB_in);
        r_size    <= mem_size;
        r_lane    <= ALUOut_in[1:0];
        r_signed  <= mem_signed;
        r_cnt     <= '0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 8'd1;
        if (bus_ack) begin
          bus_req <= 1'b0;
          if (!bus_we) ReadData_out <= w_load;
        end else if (w_timeout) begin
          bus_req      <= 1'b0;
          ReadData_out <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven and randomized checks of the MEM-stage access unit.
module tb_mem_access_unit;
  localparam int TO = 4;
  logic        clk = 1'b0, reset = 1'b1;
  logic        MemRd_in = 1'b0, MemWr_in = 1'b0, mem_signed = 1'b0, bus_ack = 1'b0;
  logic [31:0] ALUOut_in = '0, DatabusB_in = '0, bus_rdata = '0;
  logic [1:0]  mem_size = 2'b00;
  logic        bus_req, bus_we, stall_out, misalign_out, bus_err_out;
  logic [31:0] bus_addr, bus_wdata, ReadData_out;
  logic [3:0]  bus_be;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] model_rd;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, d;
    logic [1:0]  sz;
    logic        sg;
    int          ack_at;
    logic [31:0] rdata, exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          exp_stall;
    logic        exp_err, mis;
  } vec_t;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .MemRd_in(MemRd_in), .MemWr_in(MemWr_in),
    .ALUOut_in(ALUOut_in), .DatabusB_in(DatabusB_in), .mem_size(mem_size),
    .mem_signed(mem_signed), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .ReadData_out(ReadData_out), .stall_out(stall_out), .misalign_out(misalign_out),
    .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Expected results from the access rules: lane widths, shifts and masks.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev);
    int nb, lo;
    logic [31:0] mask, raw;
    bit acked;
    nb = v.sz == 2'b10 ? 1 : v.sz == 2'b01 ? 2 : 4;
    lo = int'(v.addr % 4);
    mask = nb == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
    v.mis = (lo % nb) != 0;
    v.exp_be = 4'(((1 << nb) - 1) << lo);
    v.exp_wd = nb == 1 ? (v.d & 32'hFF) * 32'h0101_0101 :
               nb == 2 ? (v.d & 32'hFFFF) * 32'h0001_0001 : v.d;
    raw = (v.rdata >> (8 * lo)) & mask;
    if (v.sg && nb < 4 && raw[8 * nb - 1]) raw = raw | ~mask;
    acked = v.ack_at >= 1 && v.ack_at <= TO;
    v.exp_err = !v.mis && !acked;
    v.exp_stall = v.mis ? 0 : (acked ? v.ack_at : TO) + 1;
    v.exp_rd = v.mis ? prev : !acked ? 32'h0 : v.wr ? prev : raw;
    return v;
  endfunction

  // Entered and left at 1 time unit after a rising edge with the unit idle.
  task automatic txn(input vec_t v, input string nm);
    int stall_n = 0, busy_n = 0;
    bit fin = 0;
    MemRd_in = v.rd; MemWr_in = v.wr; ALUOut_in = v.addr; DatabusB_in = v.d;
    mem_size = v.sz; mem_signed = v.sg; bus_rdata = v.rdata;
    if (v.mis) begin
      #2;
      chk({nm, " mis stall"}, {31'b0, stall_out}, 32'h0);
      chk({nm, " mis req"}, {31'b0, bus_req}, 32'h0);
      @(posedge clk); #1;
      MemRd_in = 1'b0; MemWr_in = 1'b0;
      chk({nm, " mis pulse"}, {31'b0, misalign_out}, 32'h1);
      chk({nm, " mis req2"}, {31'b0, bus_req}, 32'h0);
      @(posedge clk); #1;
      chk({nm, " mis pulse end"}, {31'b0, misalign_out}, 32'h0);
      chk({nm, " mis rdata"}, ReadData_out, v.exp_rd);
      return;
    end
    for (int c = 0; c < 20 && !fin; c++) begin
      #2;
      if (stall_out) stall_n++;
      if (bus_req) begin
        busy_n++;
        chk({nm, " we"}, {31'b0, bus_we}, {31'b0, v.wr});
        chk({nm, " addr"}, bus_addr, v.addr & ~32'h3);
        chk({nm, " be"}, {28'b0, bus_be}, {28'b0, v.exp_be});
        chk({nm, " wdata"}, bus_wdata, v.exp_wd);
        bus_ack = busy_n == v.ack_at;
      end else if (c > 0) begin
        fin = 1;
        chk({nm, " rdata"}, ReadData_out, v.exp_rd);
        chk({nm, " err"}, {31'b0, bus_err_out}, {31'b0, v.exp_err});
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    chk({nm, " completed"}, {31'b0, fin}, 32'h1);
    chk({nm, " stall cycles"}, 32'(stall_n), 32'(v.exp_stall));
    MemRd_in = 1'b0; MemWr_in = 1'b0;
    chk({nm, " err cleared"}, {31'b0, bus_err_out}, 32'h0);
  endtask

  vec_t tbl[10];
  vec_t v;

  initial begin
    tbl[0] = '{1, 0, 32'h1000_0004, 0, 2'b00, 0, 4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF, 0, 5, 0, 0};
    tbl[1] = '{1, 0, 32'h1000_0003, 0, 2'b10, 1, 1, 32'h8011_2233, 32'hFFFF_FF80, 4'h8, 0, 2, 0, 0};
    tbl[2] = '{1, 0, 32'h1000_0003, 0, 2'b10, 0, 1, 32'h8011_2233, 32'h0000_0080, 4'h8, 0, 2, 0, 0};
    tbl[3] = '{0, 1, 32'h1000_0002, 32'h0000_ABCD, 2'b01, 0, 2, 0, 32'h0000_0080, 4'hC, 32'hABCD_ABCD, 3, 0, 0};
    tbl[4] = '{1, 0, 32'h1000_0001, 0, 2'b00, 0, 1, 0, 32'h0000_0080, 4'h0, 0, 0, 0, 1};
    tbl[5] = '{1, 0, 32'h2000_0000, 0, 2'b00, 0, 0, 32'h55, 32'h0, 4'hF, 0, 5, 1, 0};
    tbl[6] = '{1, 0, 32'h1000_0006, 0, 2'b01, 1, 1, 32'h8001_7FFF, 32'hFFFF_8001, 4'hC, 0, 2, 0, 0};
    tbl[7] = '{1, 1, 32'h3000_0001, 32'h1234_5678, 2'b10, 0, 3, 0, 32'hFFFF_8001, 4'h2, 32'h7878_7878, 4, 0, 0};
    tbl[8] = '{1, 0, 32'h0000_0005, 0, 2'b01, 0, 1, 0, 32'hFFFF_8001, 4'h0, 0, 0, 0, 1};
    tbl[9] = '{1, 0, 32'h0000_0008, 0, 2'b11, 0, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'hF, 0, 4, 0, 0};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst req", {31'b0, bus_req}, 32'h0);
    chk("rst we", {31'b0, bus_we}, 32'h0);
    chk("rst addr", bus_addr, 32'h0);
    chk("rst wdata", bus_wdata, 32'h0);
    chk("rst be", {28'b0, bus_be}, 32'h0);
    chk("rst rdata", ReadData_out, 32'h0);
    chk("rst stall", {31'b0, stall_out}, 32'h0);
    chk("rst mis", {31'b0, misalign_out}, 32'h0);
    chk("rst err", {31'b0, bus_err_out}, 32'h0);
    for (int i = 0; i < 10; i++) txn(tbl[i], $sformatf("vec%0d", i));
    // abandon a load part-way through BUSY with an asynchronous reset
    MemRd_in = 1'b1; ALUOut_in = 32'h0000_0040; mem_size = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset req", {31'b0, bus_req}, 32'h1);
    #2 reset = 1'b1; MemRd_in = 1'b0;
    #1;
    chk("mid reset req", {31'b0, bus_req}, 32'h0);
    chk("mid reset stall", {31'b0, stall_out}, 32'h0);
    chk("mid reset rdata", ReadData_out, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    v = '{1, 0, 32'h0000_0040, 0, 2'b00, 0, 1, 32'h1122_3344, 32'h1122_3344, 4'hF, 0, 2, 0, 0};
    txn(v, "post-reset");
    model_rd = 32'h1122_3344;
    for (int i = 0; i < 60; i++) begin
      v.rd = 1'($urandom);
      v.wr = v.rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      v.sz = 2'($urandom);
      v.sg = 1'($urandom);
      v.addr = $urandom;
      if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~32'h3;
      v.d = $urandom;
      v.rdata = $urandom;
      v.ack_at = $urandom_range(0, TO + 1);
      v = model(v, model_rd);
      model_rd = v.exp_rd;
      txn(v, $sformatf("rnd%0d", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store engine. It consumes the EX/MEM pipeline register outputs and drives a req/ack data bus to data memory and peripherals. It stalls the pipeline until the bus completes, then returns aligned, extended load data toward MEM/WB. It also flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles in BUSY without bus_ack before the access is aborted (range 1..255).
SIZE_WORD, 2'b00, encoding of mem_size for a word access.
SIZE_HALF, 2'b01, encoding of mem_size for a halfword access.
SIZE_BYTE, 2'b10, encoding of mem_size for a byte access.

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous reset, active-high
MemRd_in  in  1  load request from EX/MEM
MemWr_in  in  1  store request from EX/MEM
ALUOut_in  in  32  effective byte address
DatabusB_in  in  32  store data, right-justified
mem_size  in  2  access size (see parameters); 2'b11 is treated as word
mem_signed  in  1  sign-extend loads when 1
bus_req  out  1  bus request
bus_we  out  1  1 = write
bus_addr  out  32  word address; bits [1:0] forced to 0
bus_wdata  out  32  store data replicated to all lanes
bus_be  out  4  byte enables, little-endian
bus_ack  in  1  single-cycle completion
bus_rdata  in  32  read word, valid with bus_ack
ReadData_out  out  32  aligned, extended load data
stall_out  out  1  hold IF/ID/EX/EX-MEM registers
misalign_out  out  1  one-cycle misaligned-access pulse
bus_err_out  out  1  one-cycle timeout pulse

Behaviour:
- States: IDLE, BUSY, DONE. Encoded in 2 bits; 2'b11 is illegal and recovers to IDLE.
- Reset values (asynchronous): state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, ReadData_out=0, misalign_out=0, bus_err_out=0, timeout counter=0. stall_out=0 follows from state IDLE with no request.
- access = MemRd_in|MemWr_in. If both are set, the access is a write (write wins).
- misaligned = (word & addr[1:0]!=0) | (half & addr[0]).
- IDLE, access and not misaligned:
  - stall_out=1 combinationally in the same cycle.
  - At the clock edge, register bus_req=1, bus_we, bus_addr={addr[31:2],2'b00}, bus_be and bus_wdata. Go to BUSY.
- IDLE, access and misaligned: no bus cycle, no stall. misalign_out=1 for the next cycle only.
- BUSY:
  - stall_out=1.
  - bus_req and all bus outputs are held stable until bus_ack.
  - Counter increments each cycle.
  - On bus_ack: drop bus_req at the edge, latch ReadData_out (loads only), go to DONE.
  - On counter==TIMEOUT_CYCLES-1 without ack: drop bus_req, ReadData_out=0, bus_err_out=1 for one cycle, go to DONE.
  - If bus_ack and timeout occur in the same cycle, the ack wins.
- DONE: stall_out=0 so the pipeline advances at this edge. Return to IDLE; the new EX/MEM contents are evaluated next cycle. The same instruction is never reissued.
- Byte enables and write data:
  - word: be=1111.
  - half: be=0011 if addr[1]=0, else 1100; wdata={2{D[15:0]}}.
  - byte: be=0001<<addr[1:0]; wdata={4{D[7:0]}}.
- Load extraction:
  - Select the lane given by addr[1:0] (byte) or addr[1] (half).
  - Extend with zeros, or with the lane MSB when mem_signed=1.
  - ReadData_out is held until the next load completes. Stores do not alter it.
- Load latency: one request cycle plus N cycles to ack plus one DONE cycle. With ack on the first BUSY cycle, stall_out is high for exactly 2 cycles.
- A reset mid-BUSY drops bus_req immediately and the transaction is abandoned.

Decomposition:
- Shared package mem_pkg:
  - size encodings;
  - state encoding;
  - TIMEOUT default;
  - function computing bus_be from (size, addr[1:0]).
- One sub-module, load_align: purely combinational lane select and sign/zero extension. It is reused by a future uncached path.
- The FSM, counter and bus registers stay in mem_access_unit.

Test Plan:
- Word load: addr 0x1000_0004, bus_ack after 3 cycles with rdata 0xDEADBEEF -> bus_addr 0x1000_0004, be 1111, ReadData_out 0xDEADBEEF, stall_out high for 5 cycles.
- Signed byte load: addr ...0x03, rdata 0x80112233, signed=1 -> ReadData_out 0xFFFFFF80. Repeat with signed=0 -> 0x00000080.
- Half store: addr ...0x02, data 0x0000ABCD -> be 1100, wdata 0xABCDABCD, bus_we=1. ReadData_out is unchanged.
- Misaligned word load: addr ...0x01 -> no bus_req, stall_out=0, misalign_out=1 for exactly one cycle.
- Timeout with TIMEOUT_CYCLES=4 and no ack -> bus_req low after 4 BUSY cycles, bus_err_out one-cycle pulse, ReadData_out=0, pipeline released.
- Reset asserted during BUSY -> bus_req=0 and state IDLE immediately. After reset is released, a new load completes normally.
